// File: rtl/branch_history_table.sv
// ============================================================================
// branch_history_table : gshare predictor, 64 x 2-bit counters, 6-bit GHR
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_history_table #(
  parameter int         ENTRIES     = 64,
  parameter logic [1:0] RESET_VALUE = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [7:0]  resp,
  input  logic        spec_valid,
  input  logic        spec_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [5:0]  upd_history,
  input  logic        upd_taken,
  input  logic        upd_mispredict,
  output logic [5:0]  history
);

  localparam int IDX_W = 6;

  logic [1:0]       cnt_q [ENTRIES];
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic             resp_valid_q;
  logic [7:0]       resp_q, resp_d;

  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_uidx;
  logic [1:0]       w_ucur;
  logic [1:0]       w_unext;

  // Pure XOR hash; pc[1:0] and pc[31:8] never participate.
  assign w_idx  = req_pc[7:2] ^ ghr_q;
  assign w_uidx = upd_pc[7:2] ^ upd_history;
  assign w_ucur = cnt_q[w_uidx];

  always_comb begin
    w_unext = w_ucur;
    if (upd_taken) begin
      if (w_ucur != 2'b11) w_unext = w_ucur + 2'b01;
    end else begin
      if (w_ucur != 2'b00) w_unext = w_ucur - 2'b01;
    end
  end

  // A repair wins over a same-cycle speculative shift: that fetch is killed.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && upd_mispredict) begin
      ghr_d = {upd_history[4:0], upd_taken};
    end else if (spec_valid) begin
      ghr_d = {ghr_q[4:0], spec_taken};
    end
  end

  always_comb begin
    resp_d = resp_q;
    if (req_valid) resp_d = {ghr_q, cnt_q[w_idx]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= 8'h00;
    end else begin
      ghr_q        <= ghr_d;
      resp_valid_q <= req_valid;
      resp_q       <= resp_d;
    end
  end

  // Lookup reads the pre-update array, so a same-index update is not bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= RESET_VALUE;
    end else if (upd_valid) begin
      cnt_q[w_uidx] <= w_unext;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp       = resp_q;
  assign history    = ghr_q;

endmodule

`default_nettype wire
